// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/forwarding scoreboard.
package hazard_pkg;

  // Slot rd storage is sized for the widest supported register address;
  // narrower addresses are zero-extended on both sides of every compare.
  localparam int REG_AW_MAX = 16;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  rf_en;
    logic                  load;
  } slot_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } fsm_e;

  // A slot supplies a value for addr when it holds a real register writer of addr.
  function automatic logic slot_hit(input slot_t s, input logic [REG_AW_MAX-1:0] addr);
    return s.valid & s.rf_en & (s.rd == addr);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select with youngest-stage priority, plus load-use flag.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [REG_AW_MAX-1:0] src,
  input  logic                  used,
  input  slot_t                 ex,
  input  slot_t                 mem,
  input  slot_t                 wb,
  output logic [1:0]            sel,
  output logic                  lu_hit
);

  // First match in EX, MEM, WB order; unused operands always read the RF.
  always_comb begin
    sel    = FWD_RF;
    lu_hit = 1'b0;
    if (used) begin
      if (slot_hit(ex, src)) begin
        sel    = FWD_EX;
        lu_hit = ex.load;
      end else if (slot_hit(mem, src)) begin
        sel = FWD_MEM;
      end else if (slot_hit(wb, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: private EX/MEM/WB writer scoreboard, per-operand
// forwarding, load-use stall FSM, memory-wait freeze and branch flush.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_rf_enable,
  input  logic                      id_load_instr,
  input  logic                      mem_wait,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      nop,
  output logic                      le_if_id,
  output logic                      le_pc,
  output logic                      stall_busy,
  output logic [CNT_W-1:0]          stall_cycles
);

  // Remaining bubbles after the first one, which is taken in IDLE.
  localparam logic [2:0] LU_CNT   = 3'(LOAD_LAT - 1);
  localparam bit         LU_MULTI = (LOAD_LAT > 1);

  slot_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  fsm_e              state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [NUM_SRC-1:0] lu_vec;
  logic              lu, freeze, hold, issue;

  // One forwarding selector per source operand.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_AW_MAX-1:0] src_ext;
    logic [1:0]            sel;
    assign src_ext = REG_AW_MAX'(id_src_addr[gi*REG_AW +: REG_AW]);
    fwd_select u_fwd (
      .src    (src_ext),
      .used   (id_src_used[gi]),
      .ex     (ex_q),
      .mem    (mem_q),
      .wb     (wb_q),
      .sel    (sel),
      .lu_hit (lu_vec[gi])
    );
    assign fwd_sel[2*gi +: 2] = sel;
  end

  // Pipeline control outputs; flush overrides any stall, freeze forces latches closed.
  always_comb begin
    freeze     = mem_wait & ~reset;
    lu         = |lu_vec;
    hold       = ~flush & ((state_q == STALL) | lu);
    nop        = freeze | ~hold;
    le_pc      = ~freeze & ~hold;
    le_if_id   = le_pc;
    stall_busy = (state_q == STALL);
    issue      = nop & ~flush;
  end

  // Scoreboard shift; ID enters EX only when it actually issues.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_wait) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (issue) begin
        ex_d = '{valid: id_valid, rd: REG_AW_MAX'(id_dst_addr),
                 rf_en: id_rf_enable, load: id_load_instr};
      end
    end
  end

  // Load-use stall sequencing; flush clears it even while frozen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (!mem_wait) begin
      case (state_q)
        IDLE: begin
          if (lu && LU_MULTI) begin
            state_d = STALL;
            cnt_d   = LU_CNT;
          end
        end
        STALL: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!le_pc && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  assign stall_cycles = stall_cycles_q;

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q           <= '0;
      mem_q          <= '0;
      wb_q           <= '0;
      state_q        <= IDLE;
      cnt_q          <= 3'd0;
      stall_cycles_q <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      wb_q           <= wb_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: two instances (LOAD_LAT 1 and 3) share one stimulus stream.
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [11:0] id_src_addr;
  logic [2:0]  id_src_used;
  logic [3:0]  id_dst_addr;
  logic        id_rf_enable, id_load_instr, mem_wait, flush;

  logic [5:0]  fwd1, fwd3;
  logic        nop1, lei1, lep1, busy1, nop3, lei3, lep3, busy3;
  logic [15:0] sc1;
  logic [2:0]  sc3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(4), .NUM_SRC(3), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_rf_enable(id_rf_enable),
    .id_load_instr(id_load_instr), .mem_wait(mem_wait), .flush(flush),
    .fwd_sel(fwd1), .nop(nop1), .le_if_id(lei1), .le_pc(lep1),
    .stall_busy(busy1), .stall_cycles(sc1));

  hazard_scoreboard_unit #(.REG_AW(4), .NUM_SRC(3), .LOAD_LAT(3), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_rf_enable(id_rf_enable),
    .id_load_instr(id_load_instr), .mem_wait(mem_wait), .flush(flush),
    .fwd_sel(fwd3), .nop(nop3), .le_if_id(lei3), .le_pc(lep3),
    .stall_busy(busy3), .stall_cycles(sc3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    id_valid = 1'b0; id_src_addr = '0; id_src_used = '0;
    id_dst_addr = '0; id_rf_enable = 1'b0; id_load_instr = 1'b0;
  endtask

  task automatic issue_wr(input logic [3:0] dst, input logic ld);
    id_valid = 1'b1; id_src_addr = '0; id_src_used = '0;
    id_dst_addr = dst; id_rf_enable = 1'b1; id_load_instr = ld;
  endtask

  task automatic rd(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                    input logic [2:0] used);
    id_valid = 1'b1; id_src_addr = {s2, s1, s0}; id_src_used = used;
    id_dst_addr = 4'd0; id_rf_enable = 1'b0; id_load_instr = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; idle_in(); mem_wait = 1'b0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit [4:0] exp_le3;
    bit [4:0] exp_busy3;
    exp_le3   = 5'b11000;
    exp_busy3 = 5'b00110;

    reset = 1'b1; idle_in(); mem_wait = 1'b0; flush = 1'b0;
    #2;
    chk("rst_fwd", 32'(fwd1), 32'h0);
    chk("rst_nop", 32'(nop1), 32'h1);
    chk("rst_le",  32'({lei1, lep1}), 32'h3);
    chk("rst_busy", 32'(busy3), 32'h0);
    chk("rst_sc",  32'(sc1), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ALU chain on r1: EX, then MEM, then WB.
    step(); issue_wr(4'd1, 1'b0);
    step(); rd(4'd1, 4'd1, 4'd0, 3'b011); #1;
    chk("alu_ex", 32'(fwd1), 32'h05);
    chk("alu_nop", 32'(nop1), 32'h1);
    step(); rd(4'd0, 4'd1, 4'd0, 3'b010); #1;
    chk("alu_mem", 32'(fwd1), 32'h08);
    step(); #1;
    chk("alu_wb", 32'(fwd1), 32'h0c);

    // Mixed priority: EX=r2, MEM=r3, WB=r2.
    do_reset();
    step(); issue_wr(4'd2, 1'b0);
    step(); issue_wr(4'd3, 1'b0);
    step(); issue_wr(4'd2, 1'b0);
    step(); rd(4'd2, 4'd3, 4'd4, 3'b111); #1;
    chk("mix_all", 32'(fwd1), 32'h09);
    chk("mix_all3", 32'(fwd3), 32'h09);
    id_src_used = 3'b101; #1;
    chk("mix_unused", 32'(fwd1), 32'h01);

    // Load-use on r5: dut1 one bubble, dut3 three bubbles.
    do_reset();
    step(); issue_wr(4'd5, 1'b1);
    step(); rd(4'd5, 4'd0, 4'd0, 3'b001); #1;
    chk("lu1_nop", 32'(nop1), 32'h0);
    chk("lu1_le",  32'({lei1, lep1}), 32'h0);
    chk("lu1_fwd", 32'(fwd1), 32'h01);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lu3_le_c%0d", k+1), 32'(lep3), 32'(exp_le3[k]));
      chk($sformatf("lu3_busy_c%0d", k+1), 32'(busy3), 32'(exp_busy3[k]));
      if (k == 1) begin
        chk("lu1_after_fwd", 32'(fwd1), 32'h02);
        chk("lu1_after_nop", 32'(nop1), 32'h1);
        chk("lu1_sc", 32'(sc1), 32'h1);
      end
      step();
    end
    chk("lu3_sc", 32'(sc3), 32'h3);
    chk("lu1_sc_final", 32'(sc1), 32'h1);

    // Flush in the second stall cycle of a LOAD_LAT=3 stall.
    do_reset();
    step(); issue_wr(4'd5, 1'b1);
    step(); rd(4'd5, 4'd0, 4'd0, 3'b001); #1;
    chk("fl_c1_le", 32'(lep3), 32'h0);
    step();
    chk("fl_c2_busy", 32'(busy3), 32'h1);
    flush = 1'b1; #1;
    chk("fl_c2_le", 32'({lei3, lep3}), 32'h3);
    chk("fl_c2_nop", 32'(nop3), 32'h1);
    step(); flush = 1'b0; idle_in(); #1;
    chk("fl_c3_busy", 32'(busy3), 32'h0);
    chk("fl_c3_le", 32'(lep3), 32'h1);
    chk("fl_sc", 32'(sc3), 32'h1);

    // Freeze for 4 cycles with an r6 writer in EX.
    do_reset();
    step(); issue_wr(4'd6, 1'b0);
    step(); rd(4'd6, 4'd0, 4'd0, 3'b001); mem_wait = 1'b1; #1;
    chk("frz_fwd0", 32'(fwd1), 32'h01);
    chk("frz_le", 32'({lei1, lep1}), 32'h0);
    chk("frz_nop", 32'(nop1), 32'h1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("frz_fwd%0d", k), 32'(fwd1), 32'h01);
    end
    step(); mem_wait = 1'b0; #1;
    chk("frz_sc", 32'(sc1), 32'h4);
    chk("frz_held", 32'(fwd1), 32'h01);
    chk("frz_sc3", 32'(sc3), 32'h4);
    step();
    chk("frz_adv", 32'(fwd1), 32'h02);

    // Saturation of the 3-bit counter in dut3.
    mem_wait = 1'b1;
    repeat (6) step();
    chk("sat_sc3", 32'(sc3), 32'h7);
    chk("sat_sc1", 32'(sc1), 32'ha);
    mem_wait = 1'b0;

    // Asynchronous reset in the middle of a LOAD_LAT=3 stall.
    do_reset();
    step(); issue_wr(4'd5, 1'b1);
    step(); rd(4'd5, 4'd0, 4'd0, 3'b001);
    step();
    chk("rs_busy_pre", 32'(busy3), 32'h1);
    reset = 1'b1; #1;
    chk("rs_busy", 32'(busy3), 32'h0);
    chk("rs_nop", 32'(nop3), 32'h1);
    chk("rs_le", 32'({lei3, lep3}), 32'h3);
    chk("rs_sc", 32'(sc3), 32'h0);
    chk("rs_fwd", 32'(fwd3), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
